mem_request_ctrl: RTL and testbench

- Memory-stage request controller; the consumer end of the EX/MEM register.
- Takes the MEM-stage control fields (memcuDRE, memcuDWE, memcuHALT, memOutput_Port as address, memrdat2 as store data) and drives the data-side cache request.
- Owns the pipeline advance and flush handshake: it generates the per-register write-enable (W) and flush (RST) strobes that every pipeline register samples.
- Stalls the whole pipeline while a data access or an instruction fetch is outstanding, and latches HALT.

---
 rtl/mem_request_ctrl.sv | 113 +++++++++++
 tb/tb_mem_request_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_ctrl.sv
// MEM-stage request controller: issues data-cache requests from the EX/MEM fields
// and generates the pipeline write-enable and flush strobes.
module mem_request_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              memcuDRE,
    input  logic              memcuDWE,
    input  logic              memcuHALT,
    input  logic [ADDR_W-1:0] memOutput_Port,
    input  logic [DATA_W-1:0] memrdat2,
    input  logic              brflush,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic [DATA_W-1:0] dload,
    output logic              ifW,
    output logic              idW,
    output logic              exW,
    output logic              memW,
    output logic              ifRST,
    output logic              idRST,
    output logic              exRST,
    output logic              halt,
    output logic              timeout
);
    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, DREQ, DDONE, HALTED} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             req;
    logic             adv;

    assign req     = memcuDRE | memcuDWE;
    assign cnt_inc = wait_cnt + 1'b1;

    // The pipeline only moves when no data access is pending and the fetch has landed.
    always_comb begin
        adv = 1'b0;
        case (state)
            IDLE:    adv = ihit & ~memcuHALT & ~req;
            DDONE:   adv = ihit;
            default: adv = 1'b0;
        endcase
        if (!nRST) adv = 1'b0;
    end

    assign ifW   = adv;
    assign idW   = adv;
    assign exW   = adv;
    assign memW  = adv;
    assign ifRST = brflush & adv;
    assign idRST = brflush & adv;
    assign exRST = brflush & adv;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            dload     <= '0;
            halt      <= 1'b0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memcuHALT) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (req) begin
                        dmemaddr  <= memOutput_Port;
                        dmemstore <= memrdat2;
                        dmemWEN   <= memcuDWE;
                        dmemREN   <= ~memcuDWE;
                        wait_cnt  <= '0;
                        state     <= DREQ;
                    end
                end
                DREQ: begin
                    if (dhit) begin
                        if (dmemREN) dload <= dmemload;
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= DDONE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) timeout <= 1'b1;
                    end
                end
                DDONE: begin
                    if (ihit) state <= IDLE;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Bench for mem_request_ctrl: directed scenarios followed by randomized episodes,
// all checked against a transaction-level model of the MEM-stage handshake.
module tb_mem_request_ctrl;
    localparam int MW = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        memcuDRE, memcuDWE, memcuHALT, brflush, ihit, dhit;
    logic [31:0] memOutput_Port, memrdat2, dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        ifW, idW, exW, memW, ifRST, idRST, exRST, halt, timeout;

    int n_cmp = 0;
    int n_mis = 0;
    int ren_hi = 0;

    // Model: one outstanding access at most, then a wait for the fetch to land.
    bit          m_pend, m_wr, m_fetch, m_halted, m_to;
    int          m_waited;
    logic [31:0] m_addr, m_store, m_dload;

    mem_request_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .nRST(nRST),
        .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
        .memOutput_Port(memOutput_Port), .memrdat2(memrdat2),
        .brflush(brflush), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dload(dload),
        .ifW(ifW), .idW(idW), .exW(exW), .memW(memW),
        .ifRST(ifRST), .idRST(idRST), .exRST(exRST),
        .halt(halt), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_wr = 0; m_fetch = 0; m_halted = 0; m_to = 0; m_waited = 0;
        m_addr = '0; m_store = '0; m_dload = '0;
    endtask

    function automatic bit exp_advance();
        if (!nRST || m_halted || m_pend) return 1'b0;
        if (m_fetch) return ihit;
        return ihit && !memcuHALT && !(memcuDRE || memcuDWE);
    endfunction

    task automatic check_model(input string ph);
        bit w;
        w = exp_advance();
        chk({ph, "_ren"},   dmemREN,   m_pend && !m_wr);
        chk({ph, "_wen"},   dmemWEN,   m_pend && m_wr);
        chk({ph, "_addr"},  dmemaddr,  m_addr);
        chk({ph, "_store"}, dmemstore, m_store);
        chk({ph, "_dload"}, dload,     m_dload);
        chk({ph, "_ifW"},   ifW,  w);
        chk({ph, "_idW"},   idW,  w);
        chk({ph, "_exW"},   exW,  w);
        chk({ph, "_memW"},  memW, w);
        chk({ph, "_ifRST"}, ifRST, w && brflush);
        chk({ph, "_idRST"}, idRST, w && brflush);
        chk({ph, "_exRST"}, exRST, w && brflush);
        chk({ph, "_halt"},  halt,    m_halted);
        chk({ph, "_tmo"},   timeout, m_to);
    endtask

    task automatic model_step();
        if (m_halted) return;
        if (m_pend) begin
            if (dhit) begin
                if (!m_wr) m_dload = dmemload;
                m_pend = 0; m_fetch = 1; m_waited = 0;
            end else begin
                if (m_waited < MW) m_waited++;
                if (m_waited == MW) m_to = 1;
            end
        end else if (m_fetch) begin
            if (ihit) m_fetch = 0;
        end else if (memcuHALT) begin
            m_halted = 1;
        end else if (memcuDRE || memcuDWE) begin
            m_pend = 1; m_wr = memcuDWE; m_addr = memOutput_Port; m_store = memrdat2;
            m_waited = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns on the next one.
    task automatic cycle(input string ph);
        #1;
        check_model(ph);
        if (dmemREN) ren_hi++;
        model_step();
        @(negedge CLK);
    endtask

    task automatic quiet_inputs();
        memcuDRE = 0; memcuDWE = 0; memcuHALT = 0; brflush = 0; ihit = 0; dhit = 0;
        memOutput_Port = '0; memrdat2 = '0; dmemload = '0;
    endtask

    task automatic rand_inputs();
        memcuDRE       = ($urandom_range(0, 9) < 3);
        memcuDWE       = ($urandom_range(0, 9) < 2);
        memcuHALT      = ($urandom_range(0, 63) == 0);
        brflush        = ($urandom_range(0, 9) < 3);
        ihit           = ($urandom_range(0, 9) < 6);
        dhit           = ($urandom_range(0, 9) < 4);
        memOutput_Port = $urandom;
        memrdat2       = $urandom;
        dmemload       = $urandom;
    endtask

    task automatic reset_dut(input string ph);
        nRST = 0;
        #1;
        model_reset();
        check_model(ph);
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        quiet_inputs();
        nRST = 0;
        model_reset();
        @(negedge CLK);
        reset_dut("por");

        // Reset asserted one cycle after a read is issued.
        memcuDRE = 1; memOutput_Port = 32'h0000_0100;
        cycle("mid_issue");
        memcuDRE = 0;
        chk("mid_ren_live", dmemREN, 1'b1);
        reset_dut("mid_rst");
        ihit = 1; dhit = 1; dmemload = 32'hCAFE_0001;
        #1 chk("mid_idle_W", memW, 1'b1);
        cycle("mid_after");
        dhit = 0; ihit = 0;
        chk("mid_dload_ignored", dload, 32'h0);

        // Load with dhit on the third request cycle.
        ren_hi = 0;
        memcuDRE = 1; memOutput_Port = 32'h0000_0040; dmemload = 32'hDEAD_BEEF; ihit = 1; dhit = 0;
        cycle("ld_issue");
        repeat (2) cycle("ld_wait");
        dhit = 1;
        cycle("ld_hit");
        dhit = 0; memcuDRE = 0; ihit = 1;
        #1;
        chk("ld_addr", dmemaddr, 32'h40);
        chk("ld_dload", dload, 32'hDEAD_BEEF);
        chk("ld_done_W", memW, 1'b1);
        chk("ld_ren_cycles", ren_hi, 3);
        cycle("ld_done");

        // Store with both request bits set.
        memcuDRE = 1; memcuDWE = 1; memrdat2 = 32'h1234_5678; memOutput_Port = 32'h0000_0080;
        dmemload = 32'h0BAD_F00D; ihit = 0;
        cycle("st_issue");
        memcuDRE = 0; memcuDWE = 0;
        #1;
        chk("st_wen", dmemWEN, 1'b1);
        chk("st_ren", dmemREN, 1'b0);
        chk("st_store", dmemstore, 32'h1234_5678);
        dhit = 1;
        cycle("st_hit");
        dhit = 0; ihit = 1;
        #1 chk("st_dload_kept", dload, 32'hDEAD_BEEF);
        cycle("st_done");

        // Fetch stall in IDLE, flush only on the advancing cycle.
        ihit = 0; brflush = 0;
        cycle("fs0");
        cycle("fs1");
        ihit = 1; brflush = 1;
        #1;
        chk("fs_W", memW, 1'b1);
        chk("fs_exRST", exRST, 1'b1);
        chk("fs_ifRST", ifRST, 1'b1);
        cycle("fs2");
        ihit = 0;
        #1 chk("fs_noflush", exRST, 1'b0);
        cycle("fs3");
        brflush = 0;

        // Watchdog: read that waits past MAX_WAIT, then completes.
        memcuDRE = 1; memOutput_Port = 32'h0000_0200; dmemload = 32'h5555_AAAA;
        cycle("wd_issue");
        memcuDRE = 0;
        repeat (3) cycle("wd_wait");
        chk("wd_before", timeout, 1'b0);
        cycle("wd_wait4");
        chk("wd_set", timeout, 1'b1);
        repeat (2) cycle("wd_more");
        dhit = 1;
        cycle("wd_hit");
        dhit = 0; ihit = 1;
        #1;
        chk("wd_sticky", timeout, 1'b1);
        chk("wd_dload", dload, 32'h5555_AAAA);
        cycle("wd_done");

        // Halt from IDLE with the fetch side still completing.
        memcuHALT = 1; ihit = 1;
        #1 chk("hl_W", memW, 1'b0);
        cycle("hl_take");
        memcuHALT = 0;
        for (int i = 0; i < 20; i++) begin
            ihit = 1;
            memcuDRE = $urandom_range(0, 1);
            memcuDWE = $urandom_range(0, 1);
            dhit = $urandom_range(0, 1);
            chk("hl_halt", halt, 1'b1);
            cycle("hl_hold");
        end

        // Randomized episodes, each started from reset.
        for (int ep = 0; ep < 8; ep++) begin
            reset_dut("rnd_rst");
            for (int c = 0; c < 150; c++) begin
                rand_inputs();
                cycle("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
